// File: rtl/alu_hs_pkg.sv
// Shared types for the handshaked ALU: opcodes, FSM states, flag bit positions.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_hs_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_e;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: done pulses WIDTH cycles after start; product is valid while done is high.
// Backpressure: none; a new start restarts the operation.
module alu_seq_mul #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               run;

    // product exposes the accumulator including the current step, so the
    // caller can capture the final value on the same edge that done is seen
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign done    = run && (cnt == CW'(WIDTH - 1));
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            cnt    <= '0;
            run    <= 1'b0;
        end else if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b1;
        end else if (run) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_hs.sv
// Registered-result ALU with valid/ready on both sides and a multi-cycle MUL.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL.
// Backpressure: result held until out_ready; in_ready only when idle or result is draining.
module alu_hs
    import alu_hs_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       OPCODE,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] RES,
    output logic [WIDTH-1:0] RES_HI,
    output logic [3:0]       FLAGS,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [WIDTH-1:0] W_MOD = WIDTH'(WIDTH);

    state_e             state;
    state_e             state_nxt;
    op_e                op;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] product;

    logic [WIDTH-1:0]   alu_res;
    logic [3:0]         alu_flags;
    logic [3:0]         mul_flags;
    logic               c_bit;
    logic               v_bit;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   sh;

    assign op        = op_e'(OPCODE);
    assign is_mul    = (op == OP_MUL);
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == HOLD);
    assign busy      = (state == EXEC);

    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rstn    (rstn),
        .start   (accept && is_mul),
        .a       (OP1),
        .b       (OP2),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        alu_res = '0;
        c_bit   = 1'b0;
        v_bit   = 1'b0;
        wide    = '0;
        sh      = OP2 % W_MOD;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, OP1} + {1'b0, OP2};
                alu_res = wide[WIDTH-1:0];
                c_bit   = wide[WIDTH];
                v_bit   = (OP1[WIDTH-1] == OP2[WIDTH-1]) && (alu_res[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, OP1} - {1'b0, OP2};
                alu_res = wide[WIDTH-1:0];
                c_bit   = wide[WIDTH];
                v_bit   = (OP1[WIDTH-1] != OP2[WIDTH-1]) && (alu_res[WIDTH-1] != OP1[WIDTH-1]);
            end
            OP_AND: alu_res = OP1 & OP2;
            OP_OR:  alu_res = OP1 | OP2;
            OP_XOR: alu_res = OP1 ^ OP2;
            // one guard bit catches the last bit shifted out; it stays 0 for sh=0
            OP_SHL: begin
                wide    = {1'b0, OP1} << sh;
                alu_res = wide[WIDTH-1:0];
                c_bit   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {OP1, 1'b0} >> sh;
                alu_res = wide[WIDTH:1];
                c_bit   = wide[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags      = '0;
        alu_flags[F_N] = alu_res[WIDTH-1];
        alu_flags[F_Z] = (alu_res == '0);
        alu_flags[F_C] = c_bit;
        alu_flags[F_V] = v_bit;

        mul_flags      = '0;
        mul_flags[F_N] = product[WIDTH-1];
        mul_flags[F_Z] = (product == '0);
        mul_flags[F_C] = (product[2*WIDTH-1:WIDTH] != '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul ? EXEC : HOLD;
            EXEC: if (mul_done) state_nxt = HOLD;
            HOLD: if (out_ready) state_nxt = accept ? (is_mul ? EXEC : HOLD) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // a MUL accept leaves the previous result visible until the product lands
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            RES    <= '0;
            RES_HI <= '0;
            FLAGS  <= '0;
        end else if (accept && !is_mul) begin
            RES    <= alu_res;
            RES_HI <= '0;
            FLAGS  <= alu_flags;
        end else if ((state == EXEC) && mul_done) begin
            RES    <= product[WIDTH-1:0];
            RES_HI <= product[2*WIDTH-1:WIDTH];
            FLAGS  <= mul_flags;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ops_done <= '0;
        end else if (out_valid && out_ready && (ops_done != '1)) begin
            ops_done <= ops_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_hs.sv
// Bench for alu_hs: transaction-level model compared every cycle, plus hand-computed vectors.
module tb_alu_hs;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [2:0]   OPCODE = 3'd0;
    logic [W-1:0] OP1 = '0;
    logic [W-1:0] OP2 = '0;

    logic         in_ready, out_valid, busy;
    logic [W-1:0] RES, RES_HI;
    logic [3:0]   FLAGS;
    logic [15:0]  ops_done;

    logic         s_in_ready, s_out_valid, s_busy;
    logic [W-1:0] s_RES, s_RES_HI;
    logic [3:0]   s_FLAGS;
    logic [1:0]   s_ops_done;

    alu_hs #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .out_valid(out_valid),
        .out_ready(out_ready), .RES(RES), .RES_HI(RES_HI), .FLAGS(FLAGS),
        .busy(busy), .ops_done(ops_done)
    );

    alu_hs #(.WIDTH(W), .CNT_W(2)) dut_sat (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready),
        .OPCODE(OPCODE), .OP1(OP1), .OP2(OP2), .out_valid(s_out_valid),
        .out_ready(out_ready), .RES(s_RES), .RES_HI(s_RES_HI), .FLAGS(s_FLAGS),
        .busy(s_busy), .ops_done(s_ops_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction model: a pending result appears after a countdown of cycles.
    int           m_wait  = 0;
    bit           m_valid = 0;
    bit           m_acc   = 0;
    int           m_count = 0;
    logic [W-1:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;
    logic [3:0]   m_flags = '0, p_flags = '0;

    function automatic bit exp_ready();
        return (!m_valid && m_wait == 0) || (m_valid && out_ready);
    endfunction

    function automatic void golden(input int op, input int a, input int b,
                                   output int r, output int hi, output int f);
        int full, half, sa, sb, ss, sh, c, v, p;
        full = 1 << W;
        half = 1 << (W - 1);
        sa = (a >= half) ? a - full : a;
        sb = (b >= half) ? b - full : b;
        r = 0; hi = 0; c = 0; v = 0;
        case (op)
            0: begin p = a + b; r = p % full; c = (p >= full); ss = sa + sb; v = (ss >= half || ss < -half); end
            1: begin r = (a - b + full) % full; c = (a < b); ss = sa - sb; v = (ss >= half || ss < -half); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin sh = b % W; r = (a << sh) % full; c = (sh == 0) ? 0 : ((a >> (W - sh)) & 1); end
            6: begin sh = b % W; r = a >> sh; c = (sh == 0) ? 0 : ((a >> (sh - 1)) & 1); end
            default: begin p = a * b; r = p % full; hi = p / full; c = (hi != 0); end
        endcase
        f = ((r >= half) ? 8 : 0) + ((r == 0 && hi == 0) ? 4 : 0) + (c * 2) + v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        int r, hi, f;
        if (!rstn) begin
            m_wait = 0; m_valid = 0; m_acc = 0; m_count = 0;
            m_res = '0; m_hi = '0; m_flags = '0;
        end else begin
            m_acc = in_valid && exp_ready();
            if (m_valid && out_ready) begin
                m_valid = 0;
                m_count++;
            end
            if (m_acc) begin
                golden(int'(OPCODE), int'(OP1), int'(OP2), r, hi, f);
                if (OPCODE == 3'b111) begin
                    p_res = r[W-1:0]; p_hi = hi[W-1:0]; p_flags = f[3:0];
                    m_wait = W;
                end else begin
                    m_res = r[W-1:0]; m_hi = '0; m_flags = f[3:0];
                    m_valid = 1;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_res = p_res; m_hi = p_hi; m_flags = p_flags;
                    m_valid = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, exp_ready());
        chk("out_valid", out_valid, m_valid);
        chk("busy", busy, m_wait > 0);
        chk("RES", RES, m_res);
        chk("RES_HI", RES_HI, m_hi);
        chk("FLAGS", FLAGS, m_flags);
        chk("ops_done", ops_done, m_count);
        chk("sat_ops_done", s_ops_done, (m_count > 3) ? 3 : m_count);
        chk("sat_RES", s_RES, m_res);
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        in_valid = 1'b1; OPCODE = op; OP1 = a; OP2 = b;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!m_acc && k < 50);
        chk("accept_timeout", m_acc, 1);
        in_valid = 1'b0; OPCODE = ~op; OP1 = ~a; OP2 = ~b;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic [W-1:0] eh, input logic [3:0] ef, input int elat);
        int lat, nb;
        bit rdy_seen;
        issue(op, a, b);
        lat = 1; nb = 0; rdy_seen = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            nb += int'(busy);
            rdy_seen |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, elat);
        if (op == 3'b111) begin
            chk({name, "_busy_cycles"}, nb, W);
            chk({name, "_in_ready_exec"}, rdy_seen, 0);
        end
        chk({name, "_RES"}, RES, er);
        chk({name, "_RES_HI"}, RES_HI, eh);
        chk({name, "_FLAGS"}, FLAGS, ef);
        consume();
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_RES", RES, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_in_ready", in_ready, 1);
        rstn = 1'b1;
        @(posedge clk); #1;

        //    name      op      OP1      OP2      RES      RES_HI   FLAGS    latency
        run("add",    3'b000, 4'b0100, 4'b1010, 4'b1110, 4'b0000, 4'b1000, 1);
        run("sub_eq", 3'b001, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1);
        run("sub_ov", 3'b001, 4'b0111, 4'b1000, 4'b1111, 4'b0000, 4'b1011, 1);
        run("mul",    3'b111, 4'b0100, 4'b1010, 4'b1000, 4'b0010, 4'b1010, 5);
        run("shl1",   3'b101, 4'b1010, 4'b0001, 4'b0100, 4'b0000, 4'b0010, 1);
        run("shl0",   3'b101, 4'b1010, 4'b0100, 4'b1010, 4'b0000, 4'b1000, 1);
        run("shr2",   3'b110, 4'b1011, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1);
        run("and",    3'b010, 4'b1100, 4'b1010, 4'b1000, 4'b0000, 4'b1000, 1);
        run("or",     3'b011, 4'b1100, 4'b1010, 4'b1110, 4'b0000, 4'b1000, 1);
        run("xor",    3'b100, 4'b1100, 4'b1010, 4'b0110, 4'b0000, 4'b0000, 1);
        run("mul0",   3'b111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 5);

        // stall the consumer, then drain and issue in the same cycle
        issue(3'b000, 4'b0011, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("stall_RES", RES, 4'b0100);
            chk("stall_FLAGS", FLAGS, 4'b0000);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        OPCODE = 3'b100; OP1 = 4'b1100; OP2 = 4'b1010;
        #1;
        chk("b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_out_valid", out_valid, 1);
        chk("b2b_RES", RES, 4'b0110);
        chk("b2b_ops_done", ops_done, 12);
        consume();
        chk("sat_hold", s_ops_done, 3);

        // abort a multiply partway through EXEC
        issue(3'b111, 4'b0111, 4'b0011);
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_RES", RES, 0);
        chk("abort_ops_done", ops_done, 0);
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 1);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_result", out_valid, 0);

        run("post_add", 3'b000, 4'b0001, 4'b0001, 4'b0010, 4'b0000, 4'b0000, 1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
